// File: rtl/wbus_arb_pkg.sv
// rtl/wbus_arb_pkg.sv - shared types and width helper for the wired-bus arbiter
package wbus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      TURN = 2'd2
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority picker
// Searches from i_last+1 upward with wrap, so i_last itself is considered last.
module rr_pick
   import wbus_arb_pkg::*;
#(
   parameter int N_REQ = 4
)(
   input  logic [N_REQ-1:0]         i_req,
   input  logic [idx_w(N_REQ)-1:0]  i_last,
   output logic                     o_valid,
   output logic [idx_w(N_REQ)-1:0]  o_idx
);
   localparam int W = idx_w(N_REQ);

   int w_cand;

   // Walk the ring farthest-first so the nearest set bit is the final assignment.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_cand  = 0;
      for (int i = N_REQ; i >= 1; i--) begin
         w_cand = (int'(i_last) + i) % N_REQ;
         if (i_req[w_cand]) begin
            o_valid = 1'b1;
            o_idx   = W'(w_cand);
         end
      end
   end

endmodule

// File: rtl/wired_bus_arbiter.sv
// rtl/wired_bus_arbiter.sv - round-robin owner scheduler for a shared wired net
// Owners are separated by an all-grants-low turnaround so no two drivers overlap.
module wired_bus_arbiter
   import wbus_arb_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int MAX_HOLD   = 8,
   parameter int TURNAROUND = 1
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_i,
   input  logic [N_REQ-1:0]         rel_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic                     busy_o,
   output logic [idx_w(N_REQ)-1:0]  owner_o,
   output logic                     timeout_o
);
   localparam int OW = idx_w(N_REQ);
   localparam int HW = idx_w(MAX_HOLD + 1);
   localparam int TW = idx_w(TURNAROUND + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N_REQ-1:0] r_gnt;
   logic [N_REQ-1:0] w_gnt_nxt;
   logic [OW-1:0]    r_owner;
   logic [OW-1:0]    w_owner_nxt;
   logic [HW-1:0]    r_hold;
   logic [HW-1:0]    w_hold_nxt;
   logic [TW-1:0]    r_turn;
   logic [TW-1:0]    w_turn_nxt;
   logic             r_busy;
   logic             r_timeout;
   logic             w_timeout_nxt;

   logic             w_pick_valid;
   logic [OW-1:0]    w_pick_idx;
   logic             w_own_req;
   logic             w_own_rel;
   logic             w_hold_max;
   logic             w_turn_last;
   logic             w_leave;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .i_req   (req_i),
      .i_last  (r_owner),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick_idx)
   );

   assign w_own_req   = req_i[r_owner];
   assign w_own_rel   = rel_i[r_owner];
   assign w_hold_max  = (r_hold == HW'(MAX_HOLD));
   assign w_turn_last = (r_turn == TW'(TURNAROUND));
   assign w_leave     = ~w_own_req | w_own_rel | w_hold_max;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_owner   <= OW'(N_REQ - 1);
         r_hold    <= '0;
         r_turn    <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_owner   <= w_owner_nxt;
         r_hold    <= w_hold_nxt;
         r_turn    <= w_turn_nxt;
         r_busy    <= |w_gnt_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_pick_valid) w_state_nxt = OWN;
         OWN:     if (w_leave) w_state_nxt = TURN;
         TURN:    if (w_turn_last) w_state_nxt = w_pick_valid ? OWN : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_gnt_nxt     = r_gnt;
      w_owner_nxt   = r_owner;
      w_hold_nxt    = r_hold;
      w_turn_nxt    = r_turn;
      w_timeout_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_valid) begin
               w_gnt_nxt   = N_REQ'(1) << w_pick_idx;
               w_owner_nxt = w_pick_idx;
               w_hold_nxt  = HW'(1);
            end
         end
         OWN: begin
            if (w_leave) begin
               w_gnt_nxt     = '0;
               w_hold_nxt    = '0;
               w_turn_nxt    = TW'(1);
               // A release or request drop on the same cycle outranks the hold limit.
               w_timeout_nxt = w_hold_max & w_own_req & ~w_own_rel;
            end else if (!w_hold_max) begin
               w_hold_nxt = r_hold + HW'(1);
            end
         end
         TURN: begin
            if (w_turn_last) begin
               w_turn_nxt = '0;
               if (w_pick_valid) begin
                  w_gnt_nxt   = N_REQ'(1) << w_pick_idx;
                  w_owner_nxt = w_pick_idx;
                  w_hold_nxt  = HW'(1);
               end
            end else begin
               w_turn_nxt = r_turn + TW'(1);
            end
         end
         default: begin
            w_gnt_nxt  = '0;
            w_hold_nxt = '0;
            w_turn_nxt = '0;
         end
      endcase
   end

   assign gnt_o     = r_gnt;
   assign busy_o    = r_busy;
   assign owner_o   = r_owner;
   assign timeout_o = r_timeout;

   a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_o));

   a_gnt_no_swap: assert property (@(posedge clk) disable iff (!rst_n)
      (($past(gnt_o) != '0) && (gnt_o != '0)) |-> (gnt_o == $past(gnt_o)));

endmodule

// File: tb/tb_wired_bus_arbiter.sv
// tb/tb_wired_bus_arbiter.sv - self-checking bench for wired_bus_arbiter
module tb_wired_bus_arbiter;
   localparam int N_REQ      = 4;
   localparam int MAX_HOLD   = 8;
   localparam int TURNAROUND = 1;

   logic             clk;
   logic             rst_n;
   logic [N_REQ-1:0] req_i;
   logic [N_REQ-1:0] rel_i;
   logic [N_REQ-1:0] gnt_o;
   logic             busy_o;
   logic [1:0]       owner_o;
   logic             timeout_o;

   int n_vec;
   int n_err;

   // Reference: who owns the bus, how long they have held it, how long it has been free.
   int m_owner;
   int m_last;
   int m_held;
   int m_free;
   bit m_to;

   wired_bus_arbiter #(
      .N_REQ(N_REQ), .MAX_HOLD(MAX_HOLD), .TURNAROUND(TURNAROUND)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .rel_i(rel_i),
      .gnt_o(gnt_o), .busy_o(busy_o), .owner_o(owner_o), .timeout_o(timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = N_REQ - 1;
      m_held  = 0;
      m_free  = TURNAROUND;
      m_to    = 1'b0;
   endtask

   task automatic model_update(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] l);
      int pick;
      m_to = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner] || l[m_owner] || m_held >= MAX_HOLD) begin
            m_to    = r[m_owner] && !l[m_owner];
            m_owner = -1;
            m_free  = 0;
         end else begin
            m_held++;
         end
      end else begin
         pick = -1;
         if (m_free + 1 >= TURNAROUND) begin
            for (int i = N_REQ; i >= 1; i--)
               if (r[(m_last + i) % N_REQ]) pick = (m_last + i) % N_REQ;
         end
         if (pick >= 0) begin
            m_owner = pick;
            m_last  = pick;
            m_held  = 1;
         end else if (m_free < TURNAROUND) begin
            m_free++;
         end
      end
   endtask

   task automatic compare_model();
      logic [N_REQ-1:0] eg;
      eg = (m_owner >= 0) ? N_REQ'(1) << m_owner : '0;
      chk("gnt", gnt_o, eg);
      chk("busy", busy_o, eg != '0);
      chk("owner", owner_o, m_last);
      chk("timeout", timeout_o, m_to);
   endtask

   task automatic step(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] l);
      req_i = r;
      rel_i = l;
      @(posedge clk);
      #1;
      if (rst_n) model_update(r, l);
      compare_model();
   endtask

   task automatic apply_reset(input bit lit);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      if (lit) begin
         chk("t1_gnt_async", gnt_o, 0);
         chk("t1_owner", owner_o, 3);
         chk("t1_busy", busy_o, 0);
      end
      compare_model();
      @(posedge clk);
      #1;
      compare_model();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [N_REQ-1:0] r;
      logic [N_REQ-1:0] l;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      req_i = '0;
      rel_i = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_model();
      rst_n = 1'b1;

      // T1: async reset while requester 1 owns the bus
      step(4'b0010, 4'b0000);
      chk("t1_pre_gnt", gnt_o, 4'b0010);
      step(4'b0010, 4'b0000);
      apply_reset(1'b1);

      // T3: all requesting, each owner releases after two cycles
      step(4'b1111, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         chk("t3_gnt", gnt_o, 32'(1) << (k % 4));
         step(4'b1111, 4'b0000);
         step(4'b1111, 4'(32'(1) << (k % 4)));
         chk("t3_gap", gnt_o, 0);
         if (k < 4) step(4'b1111, 4'b0000);
      end
      step(4'b0000, 4'b0000);
      step(4'b0000, 4'b0000);

      // T2: single request, dropped in cycle 4
      for (int c = 1; c <= 4; c++) begin
         step(4'b0100, 4'b0000);
         chk("t2_gnt", gnt_o, 4'b0100);
      end
      step(4'b0000, 4'b0000);
      chk("t2_gap", gnt_o, 0);
      chk("t2_owner", owner_o, 2);
      step(4'b0000, 4'b0000);

      // T4: held request hits the hold limit
      for (int c = 1; c <= 8; c++) begin
         step(4'b0001, 4'b0000);
         chk("t4_gnt", gnt_o, 4'b0001);
         chk("t4_no_to", timeout_o, 0);
      end
      step(4'b0001, 4'b0000);
      chk("t4_gap", gnt_o, 0);
      chk("t4_timeout", timeout_o, 1);
      step(4'b0001, 4'b0000);
      chk("t4_regrant", gnt_o, 4'b0001);
      chk("t4_to_clear", timeout_o, 0);

      // T5: release on the hold-limit cycle
      repeat (7) step(4'b0001, 4'b0000);
      chk("t5_still_owned", gnt_o, 4'b0001);
      step(4'b0001, 4'b0001);
      chk("t5_gnt", gnt_o, 0);
      chk("t5_timeout", timeout_o, 0);
      step(4'b0000, 4'b0000);

      // T6: req 2 arrives during the turnaround and beats the previous owner
      step(4'b0001, 4'b0000);
      chk("t6_first", gnt_o, 4'b0001);
      step(4'b0001, 4'b0001);
      step(4'b0101, 4'b0000);
      chk("t6_gnt", gnt_o, 4'b0100);
      chk("t6_owner", owner_o, 2);
      step(4'b0000, 4'b0000);
      step(4'b0000, 4'b0000);

      // Random traffic with occasional resets
      r = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < N_REQ; b++)
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         l = ($urandom_range(0, 7) == 0) ? N_REQ'($urandom) : '0;
         if ($urandom_range(0, 499) == 0) apply_reset(1'b0);
         else step(r, l);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
